corelet_ctrl: RTL
=================

CORELET_CTRL -- requirements
Module: corelet_ctrl

Interface
REQ-001 Parameter: bw, 4, activation/weight bit-width (passed to package constants only).
REQ-002 Parameter: row, 8, PE rows (L0 depth per vector).
REQ-003 Parameter: col, 8, PE columns; weight vectors per kernel position.
REQ-004 Parameter: AW, 12, SRAM address width (xmem and pmem).
REQ-005 Parameter: W_BASE, 256, xmem base address of weight vectors.
REQ-006 Ports: clk in 1, single clock; reset in 1, asynchronous, active-low.
REQ-007 Ports: start in 1, run request pulse; n_act in 8, activation vectors per pass; n_kij in 4, kernel positions.
REQ-008 Ports: busy out 1, run in progress; done out 1, one-cycle completion pulse.
REQ-009 Ports: xmem_cen out 1, xmem_wen out 1 (both active-low), xmem_a out AW, input SRAM read controls.
REQ-010 Ports: l0_wr, l0_rd, ld_mode, load, execute, ofifo_rd out 1 each, corelet drive strobes; ofifo_valid in 1.
REQ-011 Ports: pmem_cen, pmem_wen out 1 (active-low), pmem_a out AW; sfu_acc, sfu_relu out 1.

Function
REQ-012 FSM states SHALL be IDLE, W_FETCH, W_LOAD, W_SETTLE, X_FETCH, EXEC, DRAIN, ACC, FIN.
REQ-013 IDLE->W_FETCH on start; start while busy=1 SHALL be ignored.
REQ-014 start with n_act=0 or n_kij=0 SHALL go IDLE->FIN directly, no SRAM/corelet strobes.
REQ-015 W_FETCH: col cycles, xmem_cen=0, xmem_wen=1, xmem_a=W_BASE+kij*col+i; l0_wr=1 one cycle later (1-cycle SRAM latency), ld_mode=1.
REQ-016 W_LOAD: col cycles of l0_rd=1, load=1, ld_mode=1; W_SETTLE: row+col idle cycles, load=0.
REQ-017 X_FETCH: n_act cycles, xmem_a=i (0..n_act-1), l0_wr one cycle later, ld_mode=0.
REQ-018 EXEC: n_act cycles of l0_rd=1, execute=1; then DRAIN.
REQ-019 In EXEC and DRAIN, ofifo_rd SHALL equal ofifo_valid; ofifo_rd never asserted when ofifo_valid=0.
REQ-020 Each ofifo read SHALL produce a pmem write the following cycle: pmem_cen=0, pmem_wen=0, pmem_a=kij*n_act+k, k = read count.
REQ-021 DRAIN exits when k=n_act: kij<n_kij-1 -> increment kij, W_FETCH; else ACC.
REQ-022 ACC: for o=0..n_act-1, for j=0..n_kij-1 read pmem_a=j*n_act+o (pmem_cen=0, pmem_wen=1); sfu_acc=1 one cycle after each read.
REQ-023 After the last j of each o, sfu_relu SHALL pulse one cycle, coincident with cycle after final sfu_acc.
REQ-024 FIN: done=1 one cycle, then IDLE; busy=1 in every state except IDLE.
REQ-025 Address arithmetic SHALL be unsigned AW-bit, truncating; n_kij*n_act max 3825 fits AW=12.
REQ-026 pmem write (REQ-020) and ACC read SHALL never coincide; ACC entered only after last write completes.

Reset
REQ-027 reset=0 SHALL asynchronously force IDLE, all counters 0.
REQ-028 Reset values: busy, done, l0_wr, l0_rd, ld_mode, load, execute, ofifo_rd, sfu_acc, sfu_relu = 0; xmem_cen, xmem_wen, pmem_cen, pmem_wen = 1; addresses = 0.
REQ-029 Reset mid-run SHALL abort without done pulse; first start after release runs from kij=0.

Configuration
REQ-030 Macro CORELET_CTRL_RELU_EN defined: sfu_relu per REQ-023.
REQ-031 Macro undefined: sfu_relu tied 0, ACC sequencing otherwise identical.

Structure
REQ-032 Shared package corelet_pkg SHALL hold the state enum type and default bw/row/col/psum_bw/AW constants.
REQ-033 ACC-phase address/strobe sequencing SHALL be one sub-module, corelet_acc_seq, started by the main FSM.

Verification
REQ-034 n_act=4, n_kij=1: xmem_a 256..263 then 0..3; 8 load cycles; 4 pmem writes at 0..3; done once.
REQ-035 n_act=3, n_kij=2: weight addresses 256..263 then 264..271; pmem writes 0..2, 3..5; ACC reads 0,3,1,4,2,5.
REQ-036 ofifo_valid held low 10 cycles in DRAIN: FSM stays, ofifo_rd=0, no pmem write, then completes.
REQ-037 reset low during EXEC: all outputs at REQ-028 values same cycle; no done; restart succeeds.
REQ-038 start with n_act=0: done pulse 2 cycles after start, xmem_cen/pmem_cen stay 1; start during busy ignored.
REQ-039 Run REQ-035 with and without CORELET_CTRL_RELU_EN: 3 sfu_relu pulses vs none.

Source files
------------

// File: rtl/corelet_pkg.sv
// Shared constants and FSM state type for the corelet controller.
package corelet_pkg;

  localparam int BW         = 4;
  localparam int ROW        = 8;
  localparam int COL        = 8;
  localparam int PSUM_BW    = 16;
  localparam int ADDR_W     = 12;
  localparam int W_BASE_DEF = 256;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_FETCH,
    S_W_LOAD,
    S_W_SETTLE,
    S_X_FETCH,
    S_EXEC,
    S_DRAIN,
    S_ACC,
    S_FIN
  } state_e;

endpackage

// File: rtl/corelet_acc_seq.sv
// Accumulation-phase sequencer: walks pmem psums per output (o outer, kij inner).
// Macro CORELET_CTRL_RELU_EN enables the sfu_relu pulse after each output's final accumulate.
module corelet_acc_seq
  import corelet_pkg::*;
#(
  parameter int AW = ADDR_W
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic [7:0]    n_act_i,
  input  logic [3:0]    n_kij_i,
  output logic          rd_o,
  output logic [AW-1:0] addr_o,
  output logic          sfu_acc_o,
  output logic          sfu_relu_o,
  output logic          busy_o
);

  logic          run_q, run_d;
  logic [7:0]    o_q, o_d;
  logic [3:0]    j_q, j_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          acc_q, last1_q, last2_q;
  logic          last_j;

  always_comb begin
    run_d  = run_q;
    o_d    = o_q;
    j_d    = j_q;
    addr_d = addr_q;
    last_j = (j_q == n_kij_i - 4'd1);
    if (start_i) begin
      run_d  = 1'b1;
      o_d    = '0;
      j_d    = '0;
      addr_d = '0;
    end else if (run_q) begin
      if (last_j) begin
        // next output column starts at address o+1 (j=0)
        j_d    = '0;
        o_d    = o_q + 8'd1;
        addr_d = AW'(o_q + 8'd1);
        if (o_q == n_act_i - 8'd1) run_d = 1'b0;
      end else begin
        j_d    = j_q + 4'd1;
        addr_d = addr_q + AW'(n_act_i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_q   <= 1'b0;
      o_q     <= '0;
      j_q     <= '0;
      addr_q  <= '0;
      acc_q   <= 1'b0;
      last1_q <= 1'b0;
      last2_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      o_q     <= o_d;
      j_q     <= j_d;
      addr_q  <= addr_d;
      acc_q   <= run_q;
      last1_q <= run_q && last_j;
      last2_q <= last1_q;
    end
  end

  assign rd_o      = run_q;
  assign addr_o    = run_q ? addr_q : '0;
  assign sfu_acc_o = acc_q;
  assign busy_o    = run_q | acc_q | last1_q | last2_q;

`ifdef CORELET_CTRL_RELU_EN
  assign sfu_relu_o = last2_q;
`else
  assign sfu_relu_o = 1'b0;
`endif

endmodule

// File: rtl/corelet_ctrl.sv
// Corelet run controller: weight/activation loading, execution drain to pmem, then accumulation.
// Optional macro CORELET_CTRL_RELU_EN enables sfu_relu pulses in the accumulation phase.
//
// state      | meaning
// IDLE       | waiting for start
// W_FETCH    | read col weight vectors from xmem into L0
// W_LOAD     | stream L0 weights into the PE array
// W_SETTLE   | row+col idle cycles for weights to settle
// X_FETCH    | read n_act activation vectors into L0
// EXEC       | stream activations through the array
// DRAIN      | read remaining ofifo results into pmem
// ACC        | accumulate psums across kernel positions
// FIN        | one-cycle done pulse
module corelet_ctrl
  import corelet_pkg::*;
#(
  parameter int bw     = BW,
  parameter int row    = ROW,
  parameter int col    = COL,
  parameter int AW     = ADDR_W,
  parameter int W_BASE = W_BASE_DEF
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic [7:0]    n_act_i,
  input  logic [3:0]    n_kij_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          xmem_cen_o,
  output logic          xmem_wen_o,
  output logic [AW-1:0] xmem_a_o,
  output logic          l0_wr_o,
  output logic          l0_rd_o,
  output logic          ld_mode_o,
  output logic          load_o,
  output logic          execute_o,
  output logic          ofifo_rd_o,
  input  logic          ofifo_valid_i,
  output logic          pmem_cen_o,
  output logic          pmem_wen_o,
  output logic [AW-1:0] pmem_a_o,
  output logic          sfu_acc_o,
  output logic          sfu_relu_o
);

  localparam logic [7:0] COL_LAST    = 8'(col - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(row + col - 1);

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [3:0]    kij_q, kij_d;
  logic [7:0]    k_q, k_d;
  logic [7:0]    nact_q, nact_d;
  logic [3:0]    nkij_q, nkij_d;
  logic          xrd_q;
  logic          pw_q;
  logic [AW-1:0] pwa_q;

  logic          xrd, ofifo_rd, acc_start;
  logic [AW-1:0] xaddr;
  logic          acc_rd, acc_busy;
  logic [AW-1:0] acc_addr;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    kij_d     = kij_q;
    k_d       = k_q;
    nact_d    = nact_q;
    nkij_d    = nkij_q;
    xrd       = 1'b0;
    xaddr     = '0;
    ofifo_rd  = 1'b0;
    acc_start = 1'b0;
    l0_rd_o   = 1'b0;
    load_o    = 1'b0;
    execute_o = 1'b0;
    ld_mode_o = 1'b0;
    done_o    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (n_act_i == 8'd0 || n_kij_i == 4'd0) begin
            state_d = S_FIN;
          end else begin
            nact_d  = n_act_i;
            nkij_d  = n_kij_i;
            kij_d   = '0;
            cnt_d   = '0;
            k_d     = '0;
            state_d = S_W_FETCH;
          end
        end
      end
      S_W_FETCH: begin
        xrd       = 1'b1;
        xaddr     = AW'(W_BASE) + AW'(kij_q) * AW'(col) + AW'(cnt_q);
        ld_mode_o = 1'b1;
        if (cnt_q == COL_LAST) begin
          cnt_d   = '0;
          state_d = S_W_LOAD;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_W_LOAD: begin
        l0_rd_o   = 1'b1;
        load_o    = 1'b1;
        ld_mode_o = 1'b1;
        if (cnt_q == COL_LAST) begin
          cnt_d   = '0;
          state_d = S_W_SETTLE;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_W_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_X_FETCH;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_X_FETCH: begin
        xrd   = 1'b1;
        xaddr = AW'(cnt_q);
        if (cnt_q == nact_q - 8'd1) begin
          cnt_d   = '0;
          k_d     = '0;
          state_d = S_EXEC;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_EXEC: begin
        l0_rd_o   = 1'b1;
        execute_o = 1'b1;
        ofifo_rd  = ofifo_valid_i && (k_q != nact_q);
        if (ofifo_rd) k_d = k_q + 8'd1;
        if (cnt_q == nact_q - 8'd1) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_DRAIN: begin
        // k==n_act is only seen once the last read's pmem write is in flight this cycle
        if (k_q == nact_q) begin
          if (kij_q < nkij_q - 4'd1) begin
            kij_d   = kij_q + 4'd1;
            cnt_d   = '0;
            state_d = S_W_FETCH;
          end else begin
            acc_start = 1'b1;
            state_d   = S_ACC;
          end
        end else begin
          ofifo_rd = ofifo_valid_i;
          if (ofifo_rd) k_d = k_q + 8'd1;
        end
      end
      S_ACC: begin
        if (!acc_busy) state_d = S_FIN;
      end
      S_FIN: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      kij_q   <= '0;
      k_q     <= '0;
      nact_q  <= '0;
      nkij_q  <= '0;
      xrd_q   <= 1'b0;
      pw_q    <= 1'b0;
      pwa_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kij_q   <= kij_d;
      k_q     <= k_d;
      nact_q  <= nact_d;
      nkij_q  <= nkij_d;
      xrd_q   <= xrd;
      pw_q    <= ofifo_rd;
      pwa_q   <= AW'(kij_q) * AW'(nact_q) + AW'(k_q);
    end
  end

  corelet_acc_seq #(.AW(AW)) u_acc_seq (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .start_i    (acc_start),
    .n_act_i    (nact_q),
    .n_kij_i    (nkij_q),
    .rd_o       (acc_rd),
    .addr_o     (acc_addr),
    .sfu_acc_o  (sfu_acc_o),
    .sfu_relu_o (sfu_relu_o),
    .busy_o     (acc_busy)
  );

  assign busy_o     = (state_q != S_IDLE);
  assign xmem_cen_o = ~xrd;
  assign xmem_wen_o = 1'b1;
  assign xmem_a_o   = xaddr;
  assign l0_wr_o    = xrd_q;
  assign ofifo_rd_o = ofifo_rd;
  assign pmem_cen_o = ~(pw_q | acc_rd);
  assign pmem_wen_o = ~pw_q;
  assign pmem_a_o   = pw_q ? pwa_q : acc_addr;

endmodule
